piece_bag: RTL and testbench
============================

// Module: piece_bag
//
// PURPOSE
//   Tracks the Tetris "7-bag": records which of the 7 tetromino IDs (0..6) have been
//   dealt in the current bag and in what order. Packs the order into a 21-bit vector.
//   Raises done once all 7 distinct pieces are present. Sits between the random
//   piece generator, which offers candidate IDs, and the next-piece queue logic,
//   which consumes the bag vector.
//
// PARAMETERS
//   NPIECES  7  number of distinct piece IDs; fixed, not intended to be overridden
//   PW       3  width of a piece ID
//
// PORTS
//   clk       in   1   system clock, all state on rising edge
//   nreset    in   1   asynchronous reset, active-high (asserted = 1) despite the name
//   newbag    in   1   synchronous clear of bag contents; start a fresh bag
//   newpiece  in   1   qualifier: piece is a candidate for insertion this cycle
//   piece     in   3   candidate piece ID; 0..6 valid, 7 invalid
//   done      out  1   all 7 piece IDs are present in the bag
//   bag       out  21  packed order; slot k at bits [3k+2:3k], k=0 is first accepted
//
// BEHAVIOUR
//   - State:
//     - bagflags[6:0]: bit p set when piece p has been accepted; kept under this exact
//       name for hierarchical checks.
//     - bag[20:0]: registered.
//     - fill pointer cnt[2:0]: 0..7.
//   - Reset (nreset=1, async):
//     - bagflags=0, bag=0, cnt=0, done=0.
//   - Per rising edge, priority order:
//     1. newbag=1: bagflags, bag and cnt cleared to 0. newpiece is ignored that cycle.
//     2. Accept the piece when all hold:
//        - newpiece=1
//        - piece<=6
//        - bagflags[piece]==0
//        - cnt<7
//        Then:
//        - bag[3*cnt +: 3] <= piece
//        - bagflags[piece] <= 1
//        - cnt <= cnt+1
//     3. Otherwise hold all state. This covers:
//        - piece==7
//        - duplicate piece
//        - bag already full
//   - Latency: an accepted piece is visible on bag and bagflags one clock after the
//     sampling edge.
//   - newpiece held high with a changing piece inserts one piece per clock.
//   - done = &bagflags, combinational from the registered flags. It rises in the same
//     cycle the 7th flag becomes visible and falls the cycle after newbag.
//   - Unused slots in bag read 0.
//     - An empty bag and a bag holding piece 0 in slot 0 differ only in bagflags and
//       cnt.
//   - Reset asserted mid-bag aborts the bag immediately.
//     - The first piece after reset release goes to slot 0.
//
// STRUCTURE
//   - Shared package tetris_pkg:
//     - typedef logic [2:0] piece_t
//     - localparam NPIECES=7
//     - localparam PIECE_INVALID=3'd7
//   - Single flat module with no sub-modules.
//   - Slot write is a decoded per-slot enable: slot k enabled when cnt==k and accepting.
//
// TESTING
//   1. Reset pulse -> bag=0, done=0, bagflags=0.
//   2. newpiece=1 with piece 7 for one clock -> bagflags stays 7'b0000000, bag=0.
//   3. Drive 6,5,4,3,2,1,0 on consecutive clocks.
//      - bagflags grows 1000000, 1100000, ... up to 1111111.
//      - done=1 only after piece 0.
//      - bag=={3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6}.
//   4. Full bag, newpiece=1 with piece 3 -> bag and bagflags unchanged, done stays 1.
//   5. Partial bag {2,5}, then offer 2 again -> ignored.
//      - bag[5:0]=={3'd5,3'd2}, bagflags=7'b0100100.
//   6. newbag=1 for one clock, with newpiece=1 at the same time
//      -> next cycle bag=0, bagflags=0, done=0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece ID type, piece count and the invalid-ID marker.
package tetris_pkg;

    localparam int unsigned NPIECES = 7;
    localparam int unsigned PW      = 3;
    localparam int unsigned BAG_W   = NPIECES * PW;

    typedef logic [PW-1:0] piece_t;

    localparam piece_t PIECE_INVALID = 3'd7;

endpackage

// File: rtl/piece_bag.sv
// 7-bag tracker: records which tetromino IDs were dealt in the current bag and in what
// order, packed three bits per slot; done rises once every ID is present.
module piece_bag
    import tetris_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             newbag,
    input  logic             newpiece,
    input  piece_t           piece,
    output logic             done,
    output logic [BAG_W-1:0] bag
);

    logic [NPIECES-1:0] bagflags;
    logic [2:0]         r_cnt;

    logic               w_piece_valid;
    logic               w_is_dup;
    logic               w_has_room;
    logic               w_accept;
    logic [NPIECES:0]   w_flags_ext;
    logic [NPIECES-1:0] w_slot_en;
    logic [NPIECES-1:0] w_flags_next;
    logic [BAG_W-1:0]   w_bag_next;

    // ID 7 maps onto a permanently-set guard flag, so it always looks like a duplicate.
    assign w_flags_ext   = {1'b1, bagflags};
    assign w_piece_valid = (piece != PIECE_INVALID);
    assign w_is_dup      = w_flags_ext[piece];
    assign w_has_room    = (r_cnt != 3'(NPIECES));
    assign w_accept      = newpiece && w_piece_valid && !w_is_dup && w_has_room;

    always_comb begin
        w_slot_en = '0;
        for (int k = 0; k < NPIECES; k++) begin
            w_slot_en[k] = w_accept && (r_cnt == 3'(k));
        end
    end

    always_comb begin
        w_bag_next = bag;
        for (int k = 0; k < NPIECES; k++) begin
            if (w_slot_en[k]) begin
                w_bag_next[k*PW +: PW] = piece;
            end
        end
    end

    assign w_flags_next = bagflags | (7'(1) << piece);

    // newbag outranks insertion; rejected offers leave every register untouched.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            bagflags <= '0;
            bag      <= '0;
            r_cnt    <= '0;
        end else if (newbag) begin
            bagflags <= '0;
            bag      <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            bagflags <= w_flags_next;
            bag      <= w_bag_next;
            r_cnt    <= r_cnt + 3'd1;
        end
    end

    assign done = &bagflags;

endmodule

// File: tb/tb_piece_bag.sv
// Bench for piece_bag: directed 7-bag scenarios plus random offers checked against a
// queue-based model of the dealt order.
module tb_piece_bag;
    import tetris_pkg::*;

    logic        clk = 1'b0;
    logic        nreset;
    logic        newbag;
    logic        newpiece;
    piece_t      piece;
    logic        done;
    logic [20:0] bag;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned order[$];
    bit   [7:0]  seen;

    always #5 clk = ~clk;

    piece_bag dut (
        .clk      (clk),
        .nreset   (nreset),
        .newbag   (newbag),
        .newpiece (newpiece),
        .piece    (piece),
        .done     (done),
        .bag      (bag)
    );

    function automatic logic [20:0] model_bag();
        logic [20:0] v = '0;
        foreach (order[k]) v[3*k +: 3] = 3'(order[k]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [20:0] eb,
                         input logic [6:0] ef, input logic ed);
        n_tests++;
        assert (bag === eb) else begin
            n_fail++;
            $error("FAIL %s bag: observed %h expected %h", tag, bag, eb);
        end
        n_tests++;
        assert (dut.bagflags === ef) else begin
            n_fail++;
            $error("FAIL %s bagflags: observed %b expected %b", tag, dut.bagflags, ef);
        end
        n_tests++;
        assert (done === ed) else begin
            n_fail++;
            $error("FAIL %s done: observed %b expected %b", tag, done, ed);
        end
    endtask

    task automatic check_model(input string tag);
        check(tag, model_bag(), seen[6:0], order.size() == 7);
    endtask

    task automatic model_clear();
        order.delete();
        seen = '0;
    endtask

    task automatic step(input logic nb, input logic np, input logic [2:0] p);
        @(negedge clk);
        newbag   = nb;
        newpiece = np;
        piece    = p;
        @(posedge clk);
        if (nb) model_clear();
        else if (np && p <= 3'd6 && !seen[p] && order.size() < 7) begin
            order.push_back(int'(p));
            seen[p] = 1'b1;
        end
        #1;
    endtask

    initial begin
        nreset   = 1'b1;
        newbag   = 1'b0;
        newpiece = 1'b0;
        piece    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 21'd0, 7'b0, 1'b0);
        @(negedge clk);
        nreset = 1'b0;

        step(1'b0, 1'b1, 3'd7);
        check("invalid7", 21'd0, 7'b0, 1'b0);

        for (int i = 6; i >= 0; i--) begin
            step(1'b0, 1'b1, 3'(i));
            check_model("fill");
        end
        check("full_order", {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 7'b1111111, 1'b1);

        step(1'b0, 1'b1, 3'd3);
        check("full_reject", {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 7'b1111111, 1'b1);

        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd2);
        step(1'b0, 1'b1, 3'd5);
        step(1'b0, 1'b1, 3'd2);
        check("dup_reject", {15'd0, 3'd5, 3'd2}, 7'b0100100, 1'b0);

        step(1'b1, 1'b1, 3'd4);
        check("newbag_wins", 21'd0, 7'b0, 1'b0);

        step(1'b0, 1'b1, 3'd0);
        check("slot0_piece0", 21'd0, 7'b0000001, 1'b0);

        // Async reset mid-bag must clear state before the next clock edge.
        step(1'b0, 1'b1, 3'd3);
        @(negedge clk);
        newpiece = 1'b0;
        #1 nreset = 1'b1;
        #1;
        model_clear();
        check("async_reset", 21'd0, 7'b0, 1'b0);
        @(negedge clk);
        nreset = 1'b0;
        step(1'b0, 1'b1, 3'd4);
        check("after_reset", 21'd4, 7'b0010000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)));
            check_model("random");
        end

        @(negedge clk);
        newpiece = 1'b0;
        newbag   = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
